// File: rtl/fnd_pkg.sv
// Shared constants for 7-segment FND users: special digit codes, segment
// bit positions and active-high segment patterns (bit 0 = a .. bit 6 = g).
package fnd_pkg;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational digit-code to active-high gfedcba segment decoder.
// Codes 10 and 12..15 are blank, 11 is a dash.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            CODE_DASH: seg = SEG_DASH;
            default:   seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Multiplexed 7-segment FND driver: per-digit slots with leading blanking,
// frame-aligned input snapshot, per-digit dp and blink, registered outputs.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter int BLINK_FRAMES   = 25,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*N_DIGITS-1:0]   i_digits,
    input  logic [N_DIGITS-1:0]     i_dp,
    input  logic [N_DIGITS-1:0]     i_blink,
    output logic [7:0]              o_seg,
    output logic [N_DIGITS-1:0]     o_com
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(N_DIGITS);
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [7:0]          SEG_POL = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] COM_POL = {N_DIGITS{COM_ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [FCNT_W-1:0]   fcnt_reg;
    logic                ph_reg;
    logic [3:0]          snap_digits_reg [N_DIGITS];
    logic [N_DIGITS-1:0] snap_dp_reg;
    logic [N_DIGITS-1:0] snap_blink_reg;
    logic [7:0]          seg_reg;
    logic [N_DIGITS-1:0] com_reg;

    logic                slot_last;
    logic                frame_wrap;
    logic [3:0]          cur_code;
    logic [6:0]          dec_seg;
    logic [7:0]          seg_next;
    logic [N_DIGITS-1:0] com_next;

    assign slot_last  = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign frame_wrap = slot_last && (idx_reg == IDX_W'(N_DIGITS - 1));

    // Inputs are only captured at frame wrap so a frame never mixes old and new values.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_snap
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    snap_digits_reg[gi] <= CODE_BLANK;
                    snap_dp_reg[gi]     <= 1'b0;
                    snap_blink_reg[gi]  <= 1'b0;
                end else if (frame_wrap) begin
                    snap_digits_reg[gi] <= i_digits[4*gi +: 4];
                    snap_dp_reg[gi]     <= i_dp[gi];
                    snap_blink_reg[gi]  <= i_blink[gi];
                end
            end
        end
    endgenerate

    assign cur_code = snap_digits_reg[idx_reg];

    fnd_seg_decode u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    always_comb begin
        seg_next = 8'h00;
        com_next = '0;
        if (cnt_reg >= CNT_W'(BLANK_CYC)) begin
            com_next[idx_reg] = 1'b1;
            if (!(ph_reg && snap_blink_reg[idx_reg])) begin
                seg_next[6:0]  = dec_seg;
                seg_next[SEG_DP] = snap_dp_reg[idx_reg];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg  <= '0;
            idx_reg  <= '0;
            fcnt_reg <= '0;
            ph_reg   <= 1'b0;
            seg_reg  <= SEG_POL;
            com_reg  <= COM_POL;
        end else begin
            seg_reg <= seg_next ^ SEG_POL;
            com_reg <= com_next ^ COM_POL;
            if (slot_last) begin
                cnt_reg <= '0;
                if (frame_wrap) begin
                    idx_reg <= '0;
                    if (fcnt_reg == FCNT_W'(BLINK_FRAMES - 1)) begin
                        fcnt_reg <= '0;
                        ph_reg   <= ~ph_reg;
                    end else begin
                        fcnt_reg <= fcnt_reg + 1'b1;
                    end
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_seg = seg_reg;
    assign o_com = com_reg;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver (2 digits, 4-cycle slots, 1 blank cycle,
// 2-frame blink phase, active-low): per-cycle model compare plus literal checkpoints.
module tb_fnd_scan_driver;

    localparam int ND    = 2;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int BF    = 2;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    digits;
    logic [ND-1:0] dp;
    logic [ND-1:0] blink;
    logic [7:0]    o_seg;
    logic [ND-1:0] o_com;

    int checks = 0;
    int errors = 0;
    int k;

    fnd_scan_driver #(
        .N_DIGITS       (ND),
        .SCAN_DIV       (SD),
        .BLANK_CYC      (BC),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b1),
        .COM_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_digits (digits),
        .i_dp     (dp),
        .i_blink  (blink),
        .o_seg    (o_seg),
        .o_com    (o_com)
    );

    always #5 clk = ~clk;

    // Reference model: state derived from cycles elapsed since reset.
    logic [6:0]    tab [16];
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_dp, m_blink;
    logic [7:0]    exp_seg, lit_seg;
    logic [ND-1:0] exp_com, sel;
    logic          model_ok = 1'b0;
    int            t, m_cnt, m_idx, m_frame, m_ph;

    initial begin
        tab[0] = 7'h3F; tab[1] = 7'h06; tab[2]  = 7'h5B; tab[3]  = 7'h4F;
        tab[4] = 7'h66; tab[5] = 7'h6D; tab[6]  = 7'h7D; tab[7]  = 7'h07;
        tab[8] = 7'h7F; tab[9] = 7'h6F; tab[10] = 7'h00; tab[11] = 7'h40;
        tab[12] = 7'h00; tab[13] = 7'h00; tab[14] = 7'h00; tab[15] = 7'h00;
    end

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            for (int i = 0; i < ND; i++) m_dig[i] = 4'd10;
            m_dp = '0;
            m_blink = '0;
            exp_seg = 8'hFF;
            exp_com = '1;
            model_ok = 1'b1;
        end else begin
            m_cnt   = t % SD;
            m_idx   = (t / SD) % ND;
            m_frame = t / FRAME;
            m_ph    = (m_frame / BF) % 2;
            if (m_cnt < BC) begin
                exp_seg = 8'hFF;
                exp_com = '1;
            end else begin
                sel = ND'(1) << m_idx;
                exp_com = ~sel;
                lit_seg = {m_dp[m_idx], tab[m_dig[m_idx]]};
                if (m_ph == 1 && m_blink[m_idx]) lit_seg = 8'h00;
                exp_seg = ~lit_seg;
            end
            if (t % FRAME == FRAME - 1) begin
                for (int i = 0; i < ND; i++) m_dig[i] = digits[4*i +: 4];
                m_dp = dp;
                m_blink = blink;
            end
            t++;
        end
    end

    // Per-cycle comparison against the model, plus the select one-hot rule.
    int n_act;
    always @(negedge clk) begin
        if (model_ok) begin
            checks += 3;
            if (o_seg !== exp_seg) begin
                errors++;
                $display("FAIL model_seg t=%0d got %h expected %h", $time, o_seg, exp_seg);
            end
            if (o_com !== exp_com) begin
                errors++;
                $display("FAIL model_com t=%0d got %b expected %b", $time, o_com, exp_com);
            end
            n_act = 0;
            for (int i = 0; i < ND; i++) if (o_com[i] === 1'b0) n_act++;
            if (n_act > 1) begin
                errors++;
                $display("FAIL onehot t=%0d got %b expected at most one active", $time, o_com);
            end
        end
    end

    task automatic goto(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic lit(input string name, input logic [7:0] s, input logic [ND-1:0] c);
        checks++;
        if (o_seg !== s || o_com !== c) begin
            errors++;
            $display("FAIL %s k=%0d got seg=%h com=%b expected seg=%h com=%b",
                     name, k, o_seg, o_com, s, c);
        end else begin
            $display("lit %s k=%0d seg=%h com=%b", name, k, o_seg, o_com);
        end
    endtask

    initial begin
        rst = 1'b1;
        digits = 8'h27;
        dp = '0;
        blink = '0;
        k = 0;
        repeat (3) @(negedge clk);
        lit("reset_hold", 8'hFF, 2'b11);
        rst = 1'b0;
        k = -1;

        goto(0);  lit("f1_blank0", 8'hFF, 2'b11);
        goto(1);  lit("f1_d0_off", 8'hFF, 2'b10);
        goto(4);  lit("f1_blank1", 8'hFF, 2'b11);
        goto(5);  lit("f1_d1_off", 8'hFF, 2'b01);
        goto(9);  lit("f2_d0_7",   8'hF8, 2'b10);
        goto(10); digits = 8'h3A;
        goto(13); lit("f2_d1_old", 8'hA4, 2'b01);
        goto(17); lit("f3_d0_blk", 8'hFF, 2'b10);
        goto(21); lit("f3_d1_3",   8'hB0, 2'b01);
        goto(22); digits = 8'hB5; dp = 2'b01;
        goto(25); lit("f4_d0_5dp", 8'h12, 2'b10);
        goto(29); lit("f4_d1_dash", 8'hBF, 2'b01);
        goto(30); digits = 8'hCD; dp = 2'b00;
        goto(33); lit("code13",    8'hFF, 2'b10);
        goto(37); lit("code12",    8'hFF, 2'b01);
        goto(38); digits = 8'hFE;
        goto(41); lit("code14",    8'hFF, 2'b10);
        goto(45); lit("code15",    8'hFF, 2'b01);
        goto(46); digits = 8'h27; blink = 2'b10;
        goto(49); lit("blink_d0",  8'hF8, 2'b10);
        goto(53); lit("blink_f6",  8'hFF, 2'b01);
        goto(61); lit("blink_f7",  8'hFF, 2'b01);
        goto(69); lit("blink_f8",  8'hA4, 2'b01);
        goto(85); lit("blink_f10", 8'hFF, 2'b01);
        goto(101); lit("blink_f12", 8'hA4, 2'b01);
        goto(126); blink = 2'b00;
        goto(133); lit("f16_d1",   8'hA4, 2'b01);
        goto(134);
        rst = 1'b1;
        @(negedge clk);
        lit("midslot_rst", 8'hFF, 2'b11);
        rst = 1'b0;
        k = -1;
        goto(0);  lit("rr_blank0", 8'hFF, 2'b11);
        goto(1);  lit("rr_d0_off", 8'hFF, 2'b10);
        goto(5);  lit("rr_d1_off", 8'hFF, 2'b01);
        goto(9);  lit("rr_d0_7",   8'hF8, 2'b10);
        goto(13); lit("rr_d1_2",   8'hA4, 2'b01);
        goto(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
